// File: rtl/cnn_stream_pkg.sv
// Shared types and helpers for the CNN pixel-stream stages.
package cnn_stream_pkg;

    localparam int unsigned DATA_WIDTH = 8;

    typedef logic signed [DATA_WIDTH-1:0] pixel_t;

    // Line/frame framing flags carried alongside every streamed pixel
    typedef struct packed {
        logic sop;
        logic eop;
        logic sof;
        logic eof;
    } strm_flags_t;

    // Signed maximum of two pixels
    function automatic pixel_t smax(input pixel_t a, input pixel_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/max_pool_2x2_if.sv
// Pixel stream bundle: data, qualifier and framing flags, no backpressure.
interface max_pool_2x2_if;
    import cnn_stream_pkg::*;

    pixel_t      data;
    logic        valid;
    strm_flags_t flags;

    modport master (output data, valid, flags);
    modport slave  (input  data, valid, flags);
endinterface

// File: rtl/pool_line_buffer.sv
// Half-line store of even-row horizontal maxima: one write port, one registered read port.
module pool_line_buffer
    import cnn_stream_pkg::*;
#(
    parameter int unsigned DEPTH = 160,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  pixel_t        wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output pixel_t        rdata_o
);

    pixel_t mem_q [DEPTH];
    pixel_t rdata_q;

    // No reset so the array maps onto block RAM; read data holds until the next read
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 stride-2 max pooling with line/frame framing and violation flagging.
module max_pool_2x2
    import cnn_stream_pkg::*;
#(
    parameter int unsigned LINE_WIDTH = 320
) (
    input  logic           clk,
    input  logic           reset_n,
    max_pool_2x2_if.slave  pix_i,
    max_pool_2x2_if.master pool_o,
    output logic           fmt_err_o
);

    localparam int unsigned BUF_AW = $clog2(LINE_WIDTH / 2);
    localparam int unsigned COL_W  = $clog2(LINE_WIDTH + 1);

    // Input capture
    logic        in_vld_q;
    pixel_t      in_data_q;
    strm_flags_t in_flags_q;

    // Window / framing state
    logic [COL_W-1:0] col_q, col_d;
    logic             row_odd_q, row_odd_d;
    pixel_t           left_q, left_d;
    logic             synced_q, synced_d;
    logic             frame_active_q, frame_active_d;
    logic             first_out_q, first_out_d;

    // Stage 1
    logic        s1_vld_q, s1_vld_d;
    pixel_t      s1_hmax_q, s1_hmax_d;
    strm_flags_t s1_flags_q, s1_flags_d;

    // Stage 2 (outputs)
    logic        out_vld_q, out_vld_d;
    pixel_t      out_data_q, out_data_d;
    strm_flags_t out_flags_q, out_flags_d;
    logic        fmt_err_q, fmt_err_d;

    // Line buffer access
    logic              buf_we, buf_re;
    logic [BUF_AW-1:0] pair_addr;
    pixel_t            buf_rd;

    // Per-pixel decode
    logic [COL_W-1:0] cur_col;
    logic             cur_odd;
    logic             accept;
    logic             in_range;
    pixel_t           hmax;

    pool_line_buffer #(
        .DEPTH (LINE_WIDTH / 2),
        .AW    (BUF_AW)
    ) u_line_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (pair_addr),
        .wdata_i (hmax),
        .re_i    (buf_re),
        .raddr_i (pair_addr),
        .rdata_o (buf_rd)
    );

    // Column/row tracking, window formation, violation detection and output stage
    always_comb begin
        col_d          = col_q;
        row_odd_d      = row_odd_q;
        left_d         = left_q;
        synced_d       = synced_q;
        frame_active_d = frame_active_q;
        first_out_d    = first_out_q;
        s1_vld_d       = 1'b0;
        s1_hmax_d      = s1_hmax_q;
        s1_flags_d     = s1_flags_q;
        out_vld_d      = s1_vld_q;
        out_data_d     = out_data_q;
        out_flags_d    = '0;
        fmt_err_d      = 1'b0;
        buf_we         = 1'b0;
        buf_re         = 1'b0;

        cur_col   = (in_flags_q.sof | in_flags_q.sop) ? '0 : col_q;
        cur_odd   = in_flags_q.sof ? 1'b0 : row_odd_q;
        accept    = in_vld_q & (synced_q | in_flags_q.sof);
        in_range  = (cur_col < COL_W'(LINE_WIDTH));
        hmax      = smax(left_q, in_data_q);
        pair_addr = BUF_AW'(cur_col >> 1);

        if (accept) begin
            synced_d  = 1'b1;
            col_d     = in_range ? (cur_col + COL_W'(1)) : cur_col;
            row_odd_d = in_flags_q.eop ? ~cur_odd : cur_odd;
            fmt_err_d = ~in_range
                      | (in_flags_q.sof & frame_active_q)
                      | (in_flags_q.eop & ~cur_col[0])
                      | (in_flags_q.eof & ~cur_odd);
            if (in_flags_q.sof) begin
                frame_active_d = 1'b1;
                first_out_d    = 1'b1;
            end
            if (in_flags_q.eof) begin
                frame_active_d = 1'b0;
            end
            if (in_range) begin
                if (!cur_col[0]) begin
                    left_d = in_data_q;
                    buf_re = cur_odd;
                end else if (!cur_odd) begin
                    buf_we = 1'b1;
                end else begin
                    s1_vld_d       = 1'b1;
                    s1_hmax_d      = hmax;
                    s1_flags_d.sop = (pair_addr == '0);
                    s1_flags_d.eop = in_flags_q.eop;
                    s1_flags_d.sof = first_out_q;
                    s1_flags_d.eof = in_flags_q.eof;
                    first_out_d    = 1'b0;
                end
            end
        end

        if (s1_vld_q) begin
            out_data_d  = smax(s1_hmax_q, buf_rd);
            out_flags_d = s1_flags_q;
        end
    end

    // State and pipeline registers; reset flushes any in-flight window
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_vld_q       <= 1'b0;
            in_data_q      <= '0;
            in_flags_q     <= '0;
            col_q          <= '0;
            row_odd_q      <= 1'b0;
            left_q         <= '0;
            synced_q       <= 1'b0;
            frame_active_q <= 1'b0;
            first_out_q    <= 1'b0;
            s1_vld_q       <= 1'b0;
            s1_hmax_q      <= '0;
            s1_flags_q     <= '0;
            out_vld_q      <= 1'b0;
            out_data_q     <= '0;
            out_flags_q    <= '0;
            fmt_err_q      <= 1'b0;
        end else begin
            in_vld_q       <= pix_i.valid;
            in_data_q      <= pix_i.data;
            in_flags_q     <= pix_i.flags;
            col_q          <= col_d;
            row_odd_q      <= row_odd_d;
            left_q         <= left_d;
            synced_q       <= synced_d;
            frame_active_q <= frame_active_d;
            first_out_q    <= first_out_d;
            s1_vld_q       <= s1_vld_d;
            s1_hmax_q      <= s1_hmax_d;
            s1_flags_q     <= s1_flags_d;
            out_vld_q      <= out_vld_d;
            out_data_q     <= out_data_d;
            out_flags_q    <= out_flags_d;
            fmt_err_q      <= fmt_err_d;
        end
    end

    assign pool_o.data  = out_data_q;
    assign pool_o.valid = out_vld_q;
    assign pool_o.flags = out_flags_q;
    assign fmt_err_o    = fmt_err_q;

endmodule
